r_reorder_ctrl: RTL and testbench

- Control core of the R-channel reorder buffer.
- Takes R beats tagged with a unique ID (uid = {row,col}) from the slave side and emits them toward the master in per-row issue order, restoring the original AXI ID.
- Out-of-order beats are parked in the response memory and later drained from it.
- Frees each uid back to the allocator through a req/ack handshake.
- Generalises the single-beat reorder FSM with multi-beat bursts, contiguous output bursts, memory drain arbitration and backpressure on memory full.

---
 rtl/r_reorder_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_r_reorder_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_reorder_ctrl.sv
// R-channel reorder control core.
// Forwards in-order beats straight to the master, parks out-of-order beats in
// the response memory, drains parked bursts once they reach the head of their
// row, and hands each finished uid back to the allocator.
module r_reorder_ctrl #(
    parameter int ID_WIDTH   = 4,
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    localparam int ROW_W     = $clog2(NUM_ROWS),
    localparam int COL_W     = $clog2(NUM_COLS),
    localparam int UID_W     = ROW_W + COL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [UID_W-1:0]      in_uid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [RESP_WIDTH-1:0] in_resp,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RESP_WIDTH-1:0] out_resp,
    output logic                  out_last,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic [UID_W-1:0]      st_uid,
    output logic [DATA_WIDTH-1:0] st_data,
    output logic [RESP_WIDTH-1:0] st_resp,
    output logic                  st_last,
    input  logic                  rm_full,
    output logic                  rl_ready,
    input  logic                  rl_valid,
    output logic [UID_W-1:0]      rl_uid,
    input  logic [DATA_WIDTH-1:0] rl_data,
    input  logic [RESP_WIDTH-1:0] rl_resp,
    input  logic                  rl_last,
    output logic [UID_W-1:0]      restore_uid,
    input  logic [ID_WIDTH-1:0]   restored_id,
    output logic                  free_req,
    output logic [UID_W-1:0]      free_uid,
    input  logic                  free_ack
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DIRECT  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_FREE    = 2'd3;
    localparam int NUM_UIDS = NUM_ROWS * NUM_COLS;

    logic [1:0]          state_q, state_d;
    logic [UID_W-1:0]    cur_uid_q, cur_uid_d;
    logic [COL_W-1:0]    release_idx_q [NUM_ROWS];
    logic [COL_W-1:0]    release_idx_d [NUM_ROWS];
    logic [NUM_UIDS-1:0] waiting_q, waiting_d;

    logic [ROW_W-1:0]    in_row_s, cur_row_s, cand_row_s;
    logic [COL_W-1:0]    in_col_s;
    logic [NUM_ROWS-1:0] rm_hit_s;
    logic                any_hit_s, direct_hit_s;
    logic                fwd_sel_s, rel_sel_s, store_sel_s, free_sel_s;
    logic                store_hs_s, rel_done_s;

    assign in_row_s  = in_uid[UID_W-1:COL_W];
    assign in_col_s  = in_uid[COL_W-1:0];
    assign cur_row_s = cur_uid_q[UID_W-1:COL_W];

    // A beat may bypass memory only if it is its row's head and nothing of that uid is parked.
    assign direct_hit_s = in_valid & (in_col_s == release_idx_q[in_row_s]) & ~waiting_q[in_uid];
    assign store_hs_s   = store_sel_s & in_valid & ~rm_full & st_ready;
    assign rel_done_s   = rel_sel_s & rl_valid & out_ready & rl_last;

    // Find rows whose head uid is parked; the lowest such row drains first.
    always_comb begin
        rm_hit_s   = {NUM_ROWS{1'b0}};
        cand_row_s = {ROW_W{1'b0}};
        any_hit_s  = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            rm_hit_s[r] = waiting_q[{r[ROW_W-1:0], release_idx_q[r]}];
            if (rm_hit_s[r] && !any_hit_s) begin
                cand_row_s = r[ROW_W-1:0];
                any_hit_s  = 1'b1;
            end else begin
                cand_row_s = cand_row_s;
            end
        end
    end

    // Sequencing FSM: choose the path for this cycle and the next state.
    always_comb begin
        state_d     = state_q;
        cur_uid_d   = cur_uid_q;
        fwd_sel_s   = 1'b0;
        rel_sel_s   = 1'b0;
        store_sel_s = 1'b0;
        free_sel_s  = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            release_idx_d[r] = release_idx_q[r];
        end
        case (state_q)
            ST_IDLE: begin
                if (any_hit_s) begin
                    // Draining parked data takes precedence over new in-order beats.
                    store_sel_s = 1'b1;
                    cur_uid_d   = {cand_row_s, release_idx_q[cand_row_s]};
                    state_d     = ST_RELEASE;
                end else if (direct_hit_s) begin
                    fwd_sel_s = 1'b1;
                    if (out_ready) begin
                        cur_uid_d = in_uid;
                        state_d   = in_last ? ST_FREE : ST_DIRECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    store_sel_s = 1'b1;
                end
            end
            ST_DIRECT: begin
                if (in_uid == cur_uid_q) begin
                    fwd_sel_s = 1'b1;
                    if (in_valid && out_ready && in_last) begin
                        state_d = ST_FREE;
                    end else begin
                        state_d = ST_DIRECT;
                    end
                end else begin
                    store_sel_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                // Every incoming beat, even of the draining uid, goes to memory.
                rel_sel_s   = 1'b1;
                store_sel_s = 1'b1;
                if (rel_done_s) begin
                    state_d = ST_FREE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_FREE: begin
                free_sel_s  = 1'b1;
                store_sel_s = 1'b1;
                if (free_ack) begin
                    release_idx_d[cur_row_s] = release_idx_q[cur_row_s] + COL_W'(1);
                    state_d                  = ST_IDLE;
                end else begin
                    state_d = ST_FREE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Track parked uids: set on any store, cleared when the drained burst ends.
    always_comb begin
        waiting_d = waiting_q;
        if (rel_done_s) begin
            waiting_d[cur_uid_q] = 1'b0;
        end else begin
            waiting_d = waiting_q;
        end
        if (store_hs_s) begin
            waiting_d[in_uid] = 1'b1;
        end else begin
            waiting_d = waiting_d;
        end
    end

    // Drive all handshake and payload outputs from the selected path.
    always_comb begin
        out_valid   = 1'b0;
        out_data    = {DATA_WIDTH{1'b0}};
        out_resp    = {RESP_WIDTH{1'b0}};
        out_last    = 1'b0;
        restore_uid = {UID_W{1'b0}};
        in_ready    = 1'b0;
        if (fwd_sel_s) begin
            out_valid   = in_valid;
            out_data    = in_data;
            out_resp    = in_resp;
            out_last    = in_last;
            restore_uid = in_uid;
            in_ready    = in_valid & out_ready;
        end else if (rel_sel_s) begin
            out_valid   = rl_valid;
            out_data    = rl_data;
            out_resp    = rl_resp;
            out_last    = rl_last;
            restore_uid = cur_uid_q;
            in_ready    = in_valid & st_ready & ~rm_full;
        end else if (store_sel_s) begin
            in_ready = in_valid & st_ready & ~rm_full;
        end else begin
            in_ready = 1'b0;
        end
        out_id   = out_valid ? restored_id : {ID_WIDTH{1'b0}};
        st_valid = store_sel_s & in_valid & ~rm_full;
        st_uid   = st_valid ? in_uid  : {UID_W{1'b0}};
        st_data  = st_valid ? in_data : {DATA_WIDTH{1'b0}};
        st_resp  = st_valid ? in_resp : {RESP_WIDTH{1'b0}};
        st_last  = st_valid & in_last;
        rl_ready = rel_sel_s & out_ready;
        rl_uid   = rel_sel_s ? cur_uid_q : {UID_W{1'b0}};
        free_req = free_sel_s;
        free_uid = free_sel_s ? cur_uid_q : {UID_W{1'b0}};
    end

    // State registers with synchronous reset; a reset mid-burst simply abandons it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_uid_q <= {UID_W{1'b0}};
            waiting_q <= {NUM_UIDS{1'b0}};
            for (int r = 0; r < NUM_ROWS; r++) begin
                release_idx_q[r] <= {COL_W{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            cur_uid_q <= cur_uid_d;
            waiting_q <= waiting_d;
            for (int r = 0; r < NUM_ROWS; r++) begin
                release_idx_q[r] <= release_idx_d[r];
            end
        end
    end

endmodule

// File: tb/tb_r_reorder_ctrl.sv
// Directed self-checking bench for r_reorder_ctrl. The allocator lookup is
// modelled as restored_id = restore_uid ^ 4'hA; expected IDs below follow that.
module tb_r_reorder_ctrl;

    localparam int UID_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [3:0]  in_uid;
    logic [63:0] in_data;
    logic [1:0]  in_resp;
    logic        out_valid, out_ready, out_last;
    logic [3:0]  out_id;
    logic [63:0] out_data;
    logic [1:0]  out_resp;
    logic        st_valid, st_ready, st_last;
    logic [3:0]  st_uid;
    logic [63:0] st_data;
    logic [1:0]  st_resp;
    logic        rm_full;
    logic        rl_ready, rl_valid, rl_last;
    logic [3:0]  rl_uid;
    logic [63:0] rl_data;
    logic [1:0]  rl_resp;
    logic [3:0]  restore_uid, restored_id;
    logic        free_req, free_ack;
    logic [3:0]  free_uid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign restored_id = restore_uid ^ 4'hA;

    r_reorder_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_uid(in_uid),
        .in_data(in_data), .in_resp(in_resp), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_data(out_data), .out_resp(out_resp), .out_last(out_last),
        .st_valid(st_valid), .st_ready(st_ready), .st_uid(st_uid),
        .st_data(st_data), .st_resp(st_resp), .st_last(st_last),
        .rm_full(rm_full),
        .rl_ready(rl_ready), .rl_valid(rl_valid), .rl_uid(rl_uid),
        .rl_data(rl_data), .rl_resp(rl_resp), .rl_last(rl_last),
        .restore_uid(restore_uid), .restored_id(restored_id),
        .free_req(free_req), .free_uid(free_uid), .free_ack(free_ack)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        in_valid = 1'b0; in_uid = 4'h0; in_data = 64'h0; in_resp = 2'b00; in_last = 1'b0;
        rl_valid = 1'b0; rl_data = 64'h0; rl_resp = 2'b00; rl_last = 1'b0;
        free_ack = 1'b0;
    endtask

    task automatic drive_beat(input logic [3:0] uid, input logic [63:0] data, input logic last);
        in_valid = 1'b1; in_uid = uid; in_data = data; in_resp = 2'b00; in_last = last;
    endtask

    // Single-beat in-order transaction: forward it, then free it with an immediate ack.
    task automatic direct_single(input string tag, input logic [3:0] uid, input logic [63:0] data,
                                 input logic [3:0] exp_id);
        drive_beat(uid, data, 1'b1);
        #1;
        check_val({tag, "_out_valid"}, 64'(out_valid), 64'h1);
        check_val({tag, "_out_data"}, out_data, data);
        check_val({tag, "_out_id"}, 64'(out_id), 64'(exp_id));
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'h1);
        check_val({tag, "_st_valid"}, 64'(st_valid), 64'h0);
        @(negedge clk);
        quiet_inputs();
        free_ack = 1'b1;
        #1;
        check_val({tag, "_free_req"}, 64'(free_req), 64'h1);
        check_val({tag, "_free_uid"}, 64'(free_uid), 64'(uid));
        check_val({tag, "_free_out_valid"}, 64'(out_valid), 64'h0);
        @(negedge clk);
        free_ack = 1'b0;
    endtask

    // One drained beat out of the response memory.
    task automatic release_beat(input string tag, input logic [3:0] uid, input logic [63:0] data,
                                input logic last, input logic [3:0] exp_id);
        rl_valid = 1'b1; rl_data = data; rl_resp = 2'b10; rl_last = last;
        #1;
        check_val({tag, "_rl_uid"}, 64'(rl_uid), 64'(uid));
        check_val({tag, "_rl_ready"}, 64'(rl_ready), 64'h1);
        check_val({tag, "_out_valid"}, 64'(out_valid), 64'h1);
        check_val({tag, "_out_data"}, out_data, data);
        check_val({tag, "_out_id"}, 64'(out_id), 64'(exp_id));
        check_val({tag, "_out_last"}, 64'(out_last), 64'(last));
        @(negedge clk);
        rl_valid = 1'b0; rl_data = 64'h0; rl_last = 1'b0; rl_resp = 2'b00;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; st_ready = 1'b1; rm_full = 1'b0;
        quiet_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'h0);
        check_val("rst_in_ready", 64'(in_ready), 64'h0);
        check_val("rst_st_valid", 64'(st_valid), 64'h0);
        check_val("rst_free_req", 64'(free_req), 64'h0);
        check_val("rst_rl_ready", 64'(rl_ready), 64'h0);
        check_val("rst_out_id", 64'(out_id), 64'h0);
        check_val("rst_state", 64'(dut.state_q), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // In order: uid 0x0, two beats; first cycle stalled by out_ready=0.
        out_ready = 1'b0;
        drive_beat(4'h0, 64'h1111, 1'b0);
        #1;
        check_val("io_stall_out_valid", 64'(out_valid), 64'h1);
        check_val("io_stall_in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_val("io_b0_out_data", out_data, 64'h1111);
        check_val("io_b0_out_id", 64'(out_id), 64'hA);
        check_val("io_b0_in_ready", 64'(in_ready), 64'h1);
        check_val("io_b0_st_valid", 64'(st_valid), 64'h0);
        @(negedge clk);
        drive_beat(4'h0, 64'h2222, 1'b1);
        in_resp = 2'b01;
        #1;
        check_val("io_b1_out_data", out_data, 64'h2222);
        check_val("io_b1_out_last", 64'(out_last), 64'h1);
        check_val("io_b1_out_resp", 64'(out_resp), 64'h1);
        check_val("io_b1_st_valid", 64'(st_valid), 64'h0);
        @(negedge clk);
        quiet_inputs();
        #1;
        check_val("io_free_wait_req", 64'(free_req), 64'h1);
        check_val("io_free_wait_uid", 64'(free_uid), 64'h0);
        @(negedge clk);
        free_ack = 1'b1;
        @(negedge clk);
        free_ack = 1'b0;
        #1;
        check_val("io_free_done", 64'(free_req), 64'h0);
        check_val("io_release_idx0", 64'(dut.release_idx_q[0]), 64'h1);

        // Out of order on row 0: uid 0x2 parks, 0x1 (head) forwards, then 0x2 drains.
        drive_beat(4'h2, 64'h3333, 1'b1);
        #1;
        check_val("ooo_st_valid", 64'(st_valid), 64'h1);
        check_val("ooo_st_uid", 64'(st_uid), 64'h2);
        check_val("ooo_st_data", st_data, 64'h3333);
        check_val("ooo_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        check_val("ooo_waiting_set", 64'(dut.waiting_q[2]), 64'h1);
        direct_single("ooo_fwd", 4'h1, 64'h4444, 4'hB);
        #1;
        check_val("ooo_idle_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        #1;
        check_val("ooo_empty_rl_uid", 64'(rl_uid), 64'h2);
        check_val("ooo_empty_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        release_beat("ooo_rel", 4'h2, 64'h5555, 1'b1, 4'h8);
        free_ack = 1'b1;
        #1;
        check_val("ooo_rel_free_uid", 64'(free_uid), 64'h2);
        check_val("ooo_waiting_clr", 64'(dut.waiting_q[2]), 64'h0);
        @(negedge clk);
        free_ack = 1'b0;
        check_val("ooo_release_idx0", 64'(dut.release_idx_q[0]), 64'h3);

        // Wrap on row 2: cols 0..3 then 0 again.
        direct_single("wr_c0", 4'h8, 64'h8000, 4'h2);
        direct_single("wr_c1", 4'h9, 64'h8001, 4'h3);
        direct_single("wr_c2", 4'hA, 64'h8002, 4'h0);
        check_val("wr_idx_3", 64'(dut.release_idx_q[2]), 64'h3);
        direct_single("wr_c3", 4'hB, 64'h8003, 4'h1);
        check_val("wr_idx_0", 64'(dut.release_idx_q[2]), 64'h0);
        direct_single("wr_c0b", 4'h8, 64'h8004, 4'h2);
        check_val("wr_idx_1", 64'(dut.release_idx_q[2]), 64'h1);

        // Release priority: park bursts of 0x4 and 0xC while 0x9 sits in FREE.
        drive_beat(4'h9, 64'h9999, 1'b1);
        #1;
        check_val("pr_fwd9", 64'(out_valid), 64'h1);
        @(negedge clk);
        drive_beat(4'h4, 64'hA1, 1'b0);
        #1;
        check_val("pr_st4a", 64'(st_uid), 64'h4);
        @(negedge clk);
        drive_beat(4'h4, 64'hA2, 1'b1);
        @(negedge clk);
        drive_beat(4'hC, 64'hC1, 1'b0);
        #1;
        check_val("pr_stCa", 64'(st_valid), 64'h1);
        check_val("pr_free_out", 64'(out_valid), 64'h0);
        @(negedge clk);
        drive_beat(4'hC, 64'hC2, 1'b1);
        @(negedge clk);
        quiet_inputs();
        free_ack = 1'b1;
        @(negedge clk);
        free_ack = 1'b0;
        #1;
        check_val("pr_idle_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        release_beat("pr_r1a", 4'h4, 64'hA1, 1'b0, 4'hE);
        release_beat("pr_r1b", 4'h4, 64'hA2, 1'b1, 4'hE);
        free_ack = 1'b1;
        #1;
        check_val("pr_free4", 64'(free_uid), 64'h4);
        @(negedge clk);
        free_ack = 1'b0;
        #1;
        check_val("pr_gap_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        release_beat("pr_r3a", 4'hC, 64'hC1, 1'b0, 4'h6);
        release_beat("pr_r3b", 4'hC, 64'hC2, 1'b1, 4'h6);
        free_ack = 1'b1;
        #1;
        check_val("pr_freeC", 64'(free_uid), 64'hC);
        @(negedge clk);
        free_ack = 1'b0;
        direct_single("pr_row2", 4'hA, 64'hAAAA, 4'h0);

        // Backpressure: memory full blocks a non-head beat but not a head beat.
        rm_full = 1'b1;
        drive_beat(4'h6, 64'h6666, 1'b1);
        #1;
        check_val("bp_in_ready", 64'(in_ready), 64'h0);
        check_val("bp_st_valid", 64'(st_valid), 64'h0);
        check_val("bp_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        check_val("bp_not_parked", 64'(dut.waiting_q[6]), 64'h0);
        direct_single("bp_head", 4'h5, 64'h5050, 4'hF);
        rm_full = 1'b0;

        // Reset in the middle of a four-beat direct burst.
        drive_beat(4'h3, 64'h3001, 1'b0);
        #1;
        check_val("rs_b0_out_valid", 64'(out_valid), 64'h1);
        @(negedge clk);
        quiet_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rs_state", 64'(dut.state_q), 64'h0);
        check_val("rs_idx0", 64'(dut.release_idx_q[0]), 64'h0);
        check_val("rs_idx1", 64'(dut.release_idx_q[1]), 64'h0);
        check_val("rs_idx2", 64'(dut.release_idx_q[2]), 64'h0);
        check_val("rs_out_valid", 64'(out_valid), 64'h0);
        check_val("rs_free_req", 64'(free_req), 64'h0);
        check_val("rs_rl_ready", 64'(rl_ready), 64'h0);
        @(negedge clk);
        direct_single("rs_after", 4'h0, 64'h0F0F, 4'hA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
